buffer_ram_masked: RTL and testbench
====================================

# buffer_ram_masked

Parametrised successor to the fixed-width single-read buffer RAM in the RISA datapath. It keeps the simple-dual-port, fixed-latency read pipeline and adds:
- configurable width, depth and read latency
- per-lane write masks and a selectable read-during-write policy
- a read-valid pipeline with output gating
- a self-timed clear engine that zeroes the array without host writes

It sits between the systolic-array writeback path and the feeder buffers, replacing per-width RAM variants.

## Interface
- ID, 0, instance identifier; no functional effect.
- WIDTH, 64, data word width in bits.
- DEPTH, 512, number of words; power of two, at least 2.
- LANE, 8, write-mask granularity in bits; WIDTH must be a multiple of LANE.
- READ_LATENCY, 2, cycles from accepted read to data out; at least 1.
- WRITE_FIRST, 1, selects the same-address read/write policy:
  - 1: the read returns the merged new word.
  - 0: the read returns the old word.
- DEPTHAD, $clog2(DEPTH), address width (derived).
- clk  in  1  sole clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- wren  in  1  write request.
- waddr  in  DEPTHAD  write address.
- wdata  in  WIDTH  write data.
- wmask  in  WIDTH/LANE  lane enables; bit i covers wdata[i*LANE +: LANE].
- rden  in  1  read request.
- raddr  in  DEPTHAD  read address.
- rdata  out  WIDTH  read data; forced to 0 whenever rvalid is 0.
- rvalid  out  1  rdata valid strobe.
- clr_start  in  1  request to zero the whole array.
- clr_busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse on the last clear write.
- err  out  1  sticky flag: a request was dropped during a clear.

## Operation
- Reset values: rdata=0, rvalid=0, clr_busy=0, clr_done=0, err=0. The read pipeline is flushed and the clear FSM returns to IDLE.
- Memory contents are not reset. A reset during CLEAR leaves the array partially cleared, which is legal.
- Write: when wren=1 and the FSM is IDLE, each lane with wmask[i]=1 is updated at waddr. Lanes with wmask[i]=0 keep their old contents. An all-zero wmask is a no-op.
- Read: when rden=1 and the FSM is IDLE, the word at raddr enters a valid-tagged pipeline READ_LATENCY deep.
- Same-cycle read and write to the same address:
  - WRITE_FIRST=1: the read returns the lane-merged post-write word.
  - WRITE_FIRST=0: the read returns the pre-write word.
- Different addresses in the same cycle never interact.
- Clear FSM has two states, IDLE and CLEAR.
  - IDLE -> CLEAR on clr_start=1. A write or read in the same cycle as clr_start is still performed normally.
  - In CLEAR, a counter ptr runs from 0 to DEPTH-1. The FSM writes all-zero to memory[ptr] on each cycle, one word per cycle.
  - CLEAR -> IDLE after the write to DEPTH-1. clr_done=1 on that same cycle.
- clr_start during CLEAR is ignored. It neither restarts the clear nor extends it.
- wren or rden during CLEAR:
  - The request is dropped: no memory change, and no rvalid is produced for it.
  - err is set to 1 and stays 1 until rst, or until a clr_start accepted in IDLE clears it.
- Reads accepted before CLEAR entry still complete through the pipeline with their sampled data.

## Timing
- Read accepted at edge t: rvalid=1 and rdata valid after edge t+READ_LATENCY.
- Back-to-back reads give one word per cycle with no bubbles.
- The write takes effect at edge t. A read of that address accepted at edge t+1 or later sees the new data.
- clr_start sampled at edge t:
  - clr_busy=1 from edge t through edge t+DEPTH.
  - Zero writes occur at edges t+1 .. t+DEPTH.
  - clr_done is high for the single cycle following edge t+DEPTH-1 and falls with clr_busy.
- First host request accepted after a clear: the cycle in which clr_busy=0.
- err rises on the edge that samples the offending request.
- rst asserted mid-cycle forces all outputs to their reset values immediately, with no clock edge required.

## Test plan
- READ_LATENCY=2: write 0xDEADBEEF_01234567 to addr 5 with a full mask, then read addr 5 at cycle t -> rvalid=1 and rdata equal to the written word at t+2; rdata=0 on every cycle where rvalid=0.
- Lane-mask merge:
  - Stimulus: write 0xFFFF..FF to addr 9, then write 0x00..00 with wmask=0x0F.
  - Required response: a read of addr 9 returns 0xFFFFFFFF_00000000.
- Collision policy:
  - Stimulus: preload addr 3 with 0xAA..AA, then read and write addr 3 (data 0x55..55) in the same cycle.
  - WRITE_FIRST=1 -> returns 0x55..55.
  - WRITE_FIRST=0 -> returns 0xAA..AA.
  - In both cases a second read of addr 3 returns 0x55..55.
- Clear:
  - Stimulus: fill all 512 words with nonzero data, then pulse clr_start.
  - Required response: clr_busy is high for 512 cycles and clr_done pulses once. A readback of every address gives 0, with no rvalid during the busy window.
- Drop during clear:
  - Stimulus: mid-clear, issue wren to addr 600-mod-512 and rden to addr 0.
  - Required response: err=1, no rvalid, and the target word reads 0 after the clear.
  - A further clr_start in IDLE clears err.
- Reset mid-operation:
  - Stimulus: assert rst with two reads in flight and the clear at ptr=100.
  - Required response: rvalid, clr_busy and err are 0 immediately and no stale rvalid appears afterwards. After reset, a write to addr 0 followed by a read of addr 0 returns the written value.

Source files
------------

// File: rtl/buffer_ram_masked.sv
// buffer_ram_masked: simple-dual-port word buffer with per-lane write masks,
// a configurable read-during-write policy, a valid-tagged fixed-latency read
// pipeline with zero-gated output, and a self-timed clear engine.
//
// Read timing: a read sampled at edge t captures the addressed word into
// stage 0 on that edge and shifts one stage per edge, so it is presented on
// rdata/rvalid after edge t+READ_LATENCY.
//
// Handshake: there is no backpressure. A request (wren or rden) is accepted
// on any rising edge where the clear engine is idle; while the engine is
// clearing, every request is dropped and the sticky err flag is raised.
// rvalid is a one-cycle strobe per accepted read, and rdata is 0 whenever
// rvalid is 0.
module buffer_ram_masked #(
   parameter int ID           = 0,
   parameter int WIDTH        = 64,
   parameter int DEPTH        = 512,
   parameter int LANE         = 8,
   parameter int READ_LATENCY = 2,
   parameter int WRITE_FIRST  = 1,
   parameter int DEPTHAD      = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wren,
   input  logic [DEPTHAD-1:0]       waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [WIDTH/LANE-1:0]    wmask,
   input  logic                     rden,
   input  logic [DEPTHAD-1:0]       raddr,
   output logic [WIDTH-1:0]         rdata,
   output logic                     rvalid,
   input  logic                     clr_start,
   output logic                     clr_busy,
   output logic                     clr_done,
   output logic                     err
);

   localparam int NLANE = WIDTH / LANE;
   localparam logic [DEPTHAD-1:0] LAST_PTR = DEPTHAD'(DEPTH - 1);
   localparam logic [DEPTHAD-1:0] PTR_ONE  = DEPTHAD'(1);

   // ID only tags the instance; it has no functional effect.
   localparam int INSTANCE_ID = ID;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } clr_state_t;

   // Storage (contents are deliberately not reset).
   logic [WIDTH-1:0]       r_mem [DEPTH];

   // Clear engine state.
   clr_state_t             r_state;
   clr_state_t             w_state_nxt;
   logic [DEPTHAD-1:0]     r_ptr;
   logic [DEPTHAD-1:0]     w_ptr_nxt;
   logic                   r_err;

   // Decoded per-cycle controls.
   logic                   w_host_wr;
   logic                   w_host_rd;
   logic                   w_clr_wr;
   logic                   w_clr_accept;
   logic                   w_drop;
   logic                   w_clr_done;

   // Unified memory write port.
   logic [NLANE-1:0]       w_we_lane;
   logic [DEPTHAD-1:0]     w_mem_addr;
   logic [WIDTH-1:0]       w_mem_data;

   // Read path.
   logic [WIDTH-1:0]       w_rd_word;
   logic [READ_LATENCY:0]  r_pvld;
   logic [WIDTH-1:0]       r_pdata [READ_LATENCY+1];

   // Clear FSM state register and sweep pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // Clear FSM next state: gates host traffic and sequences the zero sweep.
   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_host_wr    = 1'b0;
      w_host_rd    = 1'b0;
      w_clr_wr     = 1'b0;
      w_clr_accept = 1'b0;
      w_drop       = 1'b0;
      w_clr_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Host traffic in the same cycle as clr_start is still served.
            w_host_wr = wren;
            w_host_rd = rden;
            if (clr_start) begin
               w_clr_accept = 1'b1;
               w_state_nxt  = S_CLEAR;
               w_ptr_nxt    = '0;
            end
         end
         S_CLEAR: begin
            // One zero word per cycle; clr_start is ignored here.
            w_clr_wr  = 1'b1;
            w_drop    = wren | rden;
            w_ptr_nxt = r_ptr + PTR_ONE;
            if (r_ptr == LAST_PTR) begin
               w_clr_done  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = '0;
         end
      endcase
   end

   // Sticky drop flag, cleared only by reset or a newly accepted clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_clr_accept) begin
         r_err <= 1'b0;
      end else if (w_drop) begin
         r_err <= 1'b1;
      end
   end

   // Write-port mux: the clear sweep owns the port while active.
   always_comb begin
      w_we_lane  = '0;
      w_mem_addr = waddr;
      w_mem_data = wdata;
      if (w_clr_wr) begin
         w_we_lane  = '1;
         w_mem_addr = r_ptr;
         w_mem_data = '0;
      end else if (w_host_wr) begin
         w_we_lane  = wmask;
      end
   end

   // Lane-masked memory update.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NLANE; i++) begin
         if (w_we_lane[i]) begin
            r_mem[w_mem_addr][i*LANE +: LANE] <= w_mem_data[i*LANE +: LANE];
         end
      end
   end

   // Read word with optional write-first forwarding of the masked lanes.
   always_comb begin
      w_rd_word = r_mem[raddr];
      if ((WRITE_FIRST != 0) && w_host_wr && (waddr == raddr)) begin
         for (int i = 0; i < NLANE; i++) begin
            if (wmask[i]) begin
               w_rd_word[i*LANE +: LANE] = wdata[i*LANE +: LANE];
            end
         end
      end
   end

   // Valid-tagged read pipeline; dropped reads never enter it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pvld <= '0;
         for (int k = 0; k <= READ_LATENCY; k++) begin
            r_pdata[k] <= '0;
         end
      end else begin
         r_pvld[0]  <= w_host_rd;
         r_pdata[0] <= w_host_rd ? w_rd_word : '0;
         for (int k = 1; k <= READ_LATENCY; k++) begin
            r_pvld[k]  <= r_pvld[k-1];
            r_pdata[k] <= r_pdata[k-1];
         end
      end
   end

   // Outputs are decoded from async-reset registers only.
   assign rvalid   = r_pvld[READ_LATENCY];
   assign rdata    = r_pvld[READ_LATENCY] ? r_pdata[READ_LATENCY] : '0;
   assign clr_busy = (r_state == S_CLEAR);
   assign clr_done = w_clr_done;
   assign err      = r_err;

endmodule

// File: tb/tb_buffer_ram_masked.sv
// tb_buffer_ram_masked: directed bench for buffer_ram_masked.
// A write-first instance and a read-first instance share all stimulus; the
// read-first copy is checked only where the policy differs.
module tb_buffer_ram_masked;

   localparam int W  = 64;
   localparam int D  = 512;
   localparam int AW = 9;
   localparam int L  = 2;

   localparam logic [1:0] OP_W  = 2'd0;
   localparam logic [1:0] OP_R  = 2'd1;
   localparam logic [1:0] OP_WR = 2'd2;

   typedef struct packed {
      logic [1:0]    op;
      logic [AW-1:0] waddr;
      logic [W-1:0]  wdata;
      logic [7:0]    wmask;
      logic [AW-1:0] raddr;
      logic [W-1:0]  exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wren = 1'b0;
   logic [AW-1:0] waddr = '0;
   logic [W-1:0]  wdata = '0;
   logic [7:0]    wmask = '0;
   logic          rden = 1'b0;
   logic [AW-1:0] raddr = '0;
   logic          clr_start = 1'b0;

   logic [W-1:0]  rdata, rdata_rf;
   logic          rvalid, rvalid_rf;
   logic          clr_busy, clr_busy_rf;
   logic          clr_done, clr_done_rf;
   logic          err, err_rf;

   int n_vec  = 0;
   int n_fail = 0;

   vec_t vtab [16];

   buffer_ram_masked #(.WIDTH(W), .DEPTH(D), .LANE(8), .READ_LATENCY(L), .WRITE_FIRST(1)) u_dut (
      .clk(clk), .rst(rst), .wren(wren), .waddr(waddr), .wdata(wdata), .wmask(wmask),
      .rden(rden), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
      .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done), .err(err)
   );

   buffer_ram_masked #(.WIDTH(W), .DEPTH(D), .LANE(8), .READ_LATENCY(L), .WRITE_FIRST(0)) u_dut_rf (
      .clk(clk), .rst(rst), .wren(wren), .waddr(waddr), .wdata(wdata), .wmask(wmask),
      .rden(rden), .raddr(raddr), .rdata(rdata_rf), .rvalid(rvalid_rf),
      .clr_start(clr_start), .clr_busy(clr_busy_rf), .clr_done(clr_done_rf), .err(err_rf)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic idle_inputs();
      wren = 1'b0;
      rden = 1'b0;
      clr_start = 1'b0;
   endtask

   // Drive one vector for one cycle; for reads, check the empty cycles and
   // then the returned word READ_LATENCY edges after acceptance.
   task automatic apply_vec(input string name, input vec_t v);
      @(negedge clk);
      if (v.op == OP_W || v.op == OP_WR) begin
         wren = 1'b1; waddr = v.waddr; wdata = v.wdata; wmask = v.wmask;
      end
      if (v.op == OP_R || v.op == OP_WR) begin
         rden = 1'b1; raddr = v.raddr;
      end
      @(negedge clk);
      idle_inputs();
      if (v.op != OP_W) begin
         for (int k = 0; k < L; k++) begin
            if (k > 0) @(negedge clk);
            chk({name, "_pre_vld"}, W'(rvalid), W'(0));
            chk({name, "_pre_dat"}, rdata, W'(0));
         end
         @(negedge clk);
         chk({name, "_vld"}, W'(rvalid), W'(1));
         chk({name, "_dat"}, rdata, v.exp);
      end
   endtask

   task automatic write_word(input logic [AW-1:0] a, input logic [W-1:0] d);
      vec_t v;
      v = '{op: OP_W, waddr: a, wdata: d, wmask: 8'hFF, raddr: '0, exp: '0};
      apply_vec("wr", v);
   endtask

   task automatic read_word(input string name, input logic [AW-1:0] a, input logic [W-1:0] e);
      vec_t v;
      v = '{op: OP_R, waddr: '0, wdata: '0, wmask: '0, raddr: a, exp: e};
      apply_vec(name, v);
   endtask

   initial begin
      int busy_cnt, done_cnt, done_at, rv_cnt;
      bit fin;

      vtab[0]  = '{OP_W,  9'd5,  64'hDEADBEEF_01234567, 8'hFF, 9'd0,  64'h0};
      vtab[1]  = '{OP_R,  9'd0,  64'h0,                 8'h00, 9'd5,  64'hDEADBEEF_01234567};
      vtab[2]  = '{OP_W,  9'd9,  64'hFFFFFFFF_FFFFFFFF, 8'hFF, 9'd0,  64'h0};
      vtab[3]  = '{OP_W,  9'd9,  64'h00000000_00000000, 8'h0F, 9'd0,  64'h0};
      vtab[4]  = '{OP_R,  9'd0,  64'h0,                 8'h00, 9'd9,  64'hFFFFFFFF_00000000};
      vtab[5]  = '{OP_W,  9'd7,  64'h01234567_89ABCDEF, 8'hFF, 9'd0,  64'h0};
      vtab[6]  = '{OP_W,  9'd7,  64'hFFEEDDCC_BBAA9988, 8'h81, 9'd0,  64'h0};
      vtab[7]  = '{OP_R,  9'd0,  64'h0,                 8'h00, 9'd7,  64'hFF234567_89ABCD88};
      vtab[8]  = '{OP_W,  9'd9,  64'h12345678_12345678, 8'h00, 9'd0,  64'h0};
      vtab[9]  = '{OP_R,  9'd0,  64'h0,                 8'h00, 9'd9,  64'hFFFFFFFF_00000000};
      vtab[10] = '{OP_WR, 9'd11, 64'hCAFEF00D_CAFEF00D, 8'hFF, 9'd5,  64'hDEADBEEF_01234567};
      vtab[11] = '{OP_R,  9'd0,  64'h0,                 8'h00, 9'd11, 64'hCAFEF00D_CAFEF00D};
      vtab[12] = '{OP_W,  9'd5,  64'h0,                 8'h3C, 9'd0,  64'h0};
      vtab[13] = '{OP_R,  9'd0,  64'h0,                 8'h00, 9'd5,  64'hDEAD0000_00004567};
      vtab[14] = '{OP_W,  9'd11, 64'hFFFFFFFF_FFFFFFFF, 8'h55, 9'd0,  64'h0};
      vtab[15] = '{OP_R,  9'd0,  64'h0,                 8'h00, 9'd11, 64'hCAFFF0FF_CAFFF0FF};

      // Reset values while reset is held.
      repeat (3) @(negedge clk);
      chk("rst_rdata", rdata, W'(0));
      chk("rst_rvalid", W'(rvalid), W'(0));
      chk("rst_busy", W'(clr_busy), W'(0));
      chk("rst_done", W'(clr_done), W'(0));
      chk("rst_err", W'(err), W'(0));
      rst = 1'b0;

      // Table-driven vectors.
      for (int i = 0; i < 16; i++) begin
         apply_vec($sformatf("vec%0d", i), vtab[i]);
      end

      // Back-to-back reads: one word per cycle, no bubbles.
      @(negedge clk); rden = 1'b1; raddr = 9'd5;
      @(negedge clk); raddr = 9'd9;
      @(negedge clk); raddr = 9'd7;
      @(negedge clk); rden = 1'b0;
      chk("b2b0_vld", W'(rvalid), W'(1)); chk("b2b0_dat", rdata, 64'hDEAD0000_00004567);
      @(negedge clk);
      chk("b2b1_vld", W'(rvalid), W'(1)); chk("b2b1_dat", rdata, 64'hFFFFFFFF_00000000);
      @(negedge clk);
      chk("b2b2_vld", W'(rvalid), W'(1)); chk("b2b2_dat", rdata, 64'hFF234567_89ABCD88);
      @(negedge clk);
      chk("b2b_end_vld", W'(rvalid), W'(0)); chk("b2b_end_dat", rdata, W'(0));

      // Same-address read/write collision under both policies.
      write_word(9'd3, 64'hAAAAAAAA_AAAAAAAA);
      @(negedge clk);
      wren = 1'b1; waddr = 9'd3; wdata = 64'h55555555_55555555; wmask = 8'hFF;
      rden = 1'b1; raddr = 9'd3;
      @(negedge clk); idle_inputs();
      @(negedge clk);
      @(negedge clk);
      chk("col_wf_vld", W'(rvalid), W'(1));
      chk("col_wf_dat", rdata, 64'h55555555_55555555);
      chk("col_rf_vld", W'(rvalid_rf), W'(1));
      chk("col_rf_dat", rdata_rf, 64'hAAAAAAAA_AAAAAAAA);
      read_word("col_again", 9'd3, 64'h55555555_55555555);
      chk("col_again_rf", rdata_rf, 64'h55555555_55555555);

      // Fill every word with nonzero data.
      for (int a = 0; a < D; a++) begin
         @(negedge clk);
         wren = 1'b1; waddr = AW'(a); wdata = 64'hF00D0000_00000000 | W'(a); wmask = 8'hFF;
      end
      @(negedge clk); idle_inputs();

      // Clear with a dropped write and read in the middle.
      clr_start = 1'b1;
      busy_cnt = 0; done_cnt = 0; done_at = 0; rv_cnt = 0; fin = 1'b0;
      for (int c = 0; c < 2000 && !fin; c++) begin
         @(negedge clk);
         clr_start = 1'b0;
         if (clr_busy) busy_cnt++;
         if (clr_done) begin done_cnt++; done_at = busy_cnt; end
         if (rvalid) rv_cnt++;
         if (busy_cnt == 101 && wren) begin
            idle_inputs();
            chk("drop_err", W'(err), W'(1));
         end
         if (busy_cnt == 100 && !wren) begin
            chk("pre_drop_err", W'(err), W'(0));
            wren = 1'b1; waddr = AW'(600 % 512); wdata = 64'h12345678_9ABCDEF0; wmask = 8'hFF;
            rden = 1'b1; raddr = 9'd0;
         end
         if (!clr_busy) fin = 1'b1;
      end
      idle_inputs();
      chk("clr_end", W'(clr_busy), W'(0));
      chk("clr_busy_cycles", W'(busy_cnt), W'(D));
      chk("clr_done_count", W'(done_cnt), W'(1));
      chk("clr_done_last", W'(done_at), W'(D));
      chk("clr_no_rvalid", W'(rv_cnt), W'(0));
      chk("clr_err_sticky", W'(err), W'(1));

      // Readback of every word after the clear.
      for (int a = 0; a < D; a++) begin
         read_word("clr_rd", AW'(a), W'(0));
      end
      chk("err_still", W'(err), W'(1));

      // Second clear from IDLE: clears err, same-cycle read still served.
      write_word(9'd1, 64'h11112222_33334444);
      @(negedge clk);
      clr_start = 1'b1; rden = 1'b1; raddr = 9'd1;
      @(negedge clk); idle_inputs();
      busy_cnt = 1; done_cnt = 0;
      chk("clr2_err", W'(err), W'(0));
      chk("clr2_busy", W'(clr_busy), W'(1));
      @(negedge clk); busy_cnt++;
      chk("clr2_rd_pre", W'(rvalid), W'(0));
      @(negedge clk); busy_cnt++;
      chk("clr2_rd_vld", W'(rvalid), W'(1));
      chk("clr2_rd_dat", rdata, 64'h11112222_33334444);
      fin = 1'b0;
      for (int c = 0; c < 2000 && !fin; c++) begin
         if (clr_done) done_cnt++;
         @(negedge clk);
         if (clr_busy) busy_cnt++; else fin = 1'b1;
      end
      chk("clr2_end", W'(clr_busy), W'(0));
      chk("clr2_busy_cycles", W'(busy_cnt), W'(D));
      chk("clr2_done_count", W'(done_cnt), W'(1));

      // Reset in the middle of a clear at ptr=100 with err set.
      @(negedge clk); clr_start = 1'b1;
      @(negedge clk); clr_start = 1'b0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (k == 50) begin wren = 1'b1; waddr = 9'd400; wdata = '1; wmask = 8'hFF; end
         if (k == 51) idle_inputs();
      end
      chk("pre_rst_busy", W'(clr_busy), W'(1));
      chk("pre_rst_err", W'(err), W'(1));
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", W'(clr_busy), W'(0));
      chk("arst_err", W'(err), W'(0));
      chk("arst_done", W'(clr_done), W'(0));
      #1 rst = 1'b0;

      // Reset with two reads in flight, one already at the output.
      @(negedge clk); rden = 1'b1; raddr = 9'd5;
      @(negedge clk); raddr = 9'd9;
      @(negedge clk); rden = 1'b0;
      @(negedge clk);
      chk("inflight_vld", W'(rvalid), W'(1));
      #2 rst = 1'b1;
      #1;
      chk("arst_rvalid", W'(rvalid), W'(0));
      chk("arst_rdata", rdata, W'(0));
      #1 rst = 1'b0;
      rv_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (rvalid) rv_cnt++;
      end
      chk("no_stale_rvalid", W'(rv_cnt), W'(0));
      write_word(9'd0, 64'h0F1E2D3C_4B5A6978);
      read_word("post_rst_rd", 9'd0, 64'h0F1E2D3C_4B5A6978);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
